// File: rtl/dft_collect_pkg.sv
// Shared types for the DFT scan-dump collector: state encoding,
// error codes and the checksum step used when DUMP_CHECKSUM_EN is set.
package dft_collect_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_SPACE = 3'd1,
      S_REQ        = 3'd2,
      S_CAPTURE    = 3'd3,
      S_COMMIT_ACK = 3'd4
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;
   localparam logic [1:0] ERR_COUNT    = 2'd3;

   function automatic logic [31:0] csum_step(
      input logic [31:0] c,
      input logic [31:0] w
   );
      return {c[30:0], c[31]} ^ w;
   endfunction

endpackage

// File: rtl/dft_capture_fifo.sv
// Single-clock first-word-fall-through capture FIFO with occupancy
// count and a one-cycle overflow flag for writes dropped while full.
module dft_capture_fifo #(
   parameter  int DEPTH = 64,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [AW:0]      fill,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             full;
   logic             rd_fire;
   logic             wr_fire;

   assign full     = (fill == (AW+1)'(DEPTH));
   assign rd_valid = (fill != '0);
   assign rd_fire  = rd_en && rd_valid;
   // a read in the same cycle frees the slot a full-FIFO write needs
   assign wr_fire  = wr_en && (!full || rd_fire);
   assign overflow = wr_en && !wr_fire;
   assign rd_data  = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr_fire) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         fill <= '0;
      end else begin
         if (wr_fire) wptr <= wptr + AW'(1);
         if (rd_fire) rptr <= rptr + AW'(1);
         unique case ({wr_fire, rd_fire})
            2'b10:   fill <= fill + (AW+1)'(1);
            2'b01:   fill <= fill - (AW+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dft_dump_collector.sv
// Host-side scan-dump collector: issues DFT dump ops, captures strobed words.
// Optional running checksum output csum enabled by DUMP_CHECKSUM_EN.
module dft_dump_collector
   import dft_collect_pkg::*;
#(
   parameter  int WORDS_PER_OP = 32,
   parameter  int FIFO_DEPTH   = 64,
   parameter  int ACK_TIMEOUT  = 1024,
   localparam int FW           = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          err,
   input  logic          clr_err,
   output logic [1:0]    err_code,
   output logic          dft_val_op,
   input  logic          dft_op_ack,
   input  logic [31:0]   dft_out,
   input  logic          dft_out_strobe,
   input  logic          dft_op_commit,
   output logic          dft_commit_ack,
   output logic [31:0]   rd_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [FW-1:0] fill
`ifdef DUMP_CHECKSUM_EN
   ,
   output logic [31:0]   csum
`endif
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int WW = 16;
   localparam logic [FW-1:0] DEPTH_F = FW'(FIFO_DEPTH);
   localparam logic [FW-1:0] WPO_F   = FW'(WORDS_PER_OP);

   state_t        state;
   state_t        state_n;
   logic [TW-1:0] tcnt;
   logic [WW-1:0] wcnt;
   logic          space_ok;
   logic          capture;
   logic          tmo;
   logic          overflow;
   logic          count_err;
   logic [1:0]    new_code;

   assign space_ok = (DEPTH_F - fill) >= WPO_F;
   // a strobe riding on the accepting ack cycle belongs to this dump
   assign capture  = dft_out_strobe &&
                     ((state == S_CAPTURE) ||
                      (state == S_REQ && dft_op_ack));
   assign busy     = (state != S_IDLE);
   assign err      = (err_code != ERR_NONE);

   dft_capture_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (capture),
      .wr_data  (dft_out),
      .rd_en    (rd_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .fill     (fill),
      .overflow (overflow)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n        = state;
      dft_val_op     = 1'b0;
      dft_commit_ack = 1'b0;
      tmo            = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_n = S_WAIT_SPACE;
         end
         S_WAIT_SPACE: begin
            if (space_ok) state_n = S_REQ;
         end
         S_REQ: begin
            dft_val_op = 1'b1;
            if (dft_op_ack) begin
               state_n = S_CAPTURE;
            end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
               state_n = S_IDLE;
               tmo     = 1'b1;
            end
         end
         S_CAPTURE: begin
            if (dft_op_commit) state_n = S_COMMIT_ACK;
         end
         S_COMMIT_ACK: begin
            dft_commit_ack = 1'b1;
            state_n        = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcnt <= '0;
      end else if (state == S_REQ && !dft_op_ack) begin
         tcnt <= tcnt + TW'(1);
      end else begin
         tcnt <= '0;
      end
   end

   // saturating so an over-long dump can never alias to a good count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wcnt <= '0;
      end else if (state == S_WAIT_SPACE) begin
         wcnt <= '0;
      end else if (capture && wcnt != '1) begin
         wcnt <= wcnt + WW'(1);
      end
   end

   assign count_err = (state == S_COMMIT_ACK) &&
                      (wcnt != WW'(WORDS_PER_OP));

   always_comb begin
      new_code = ERR_NONE;
      if (tmo)            new_code = ERR_TIMEOUT;
      else if (overflow)  new_code = ERR_OVERFLOW;
      else if (count_err) new_code = ERR_COUNT;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_code <= ERR_NONE;
      end else if (new_code != ERR_NONE &&
                   (err_code == ERR_NONE || clr_err)) begin
         err_code <= new_code;
      end else if (clr_err) begin
         err_code <= ERR_NONE;
      end
   end

`ifdef DUMP_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csum <= '0;
      end else if (state == S_WAIT_SPACE && space_ok) begin
         csum <= '0;
      end else if (capture) begin
         csum <= csum_step(csum, dft_out);
      end
   end
`endif

endmodule

// File: tb/tb_dft_dump_collector.sv
// Directed self-checking bench for dft_dump_collector (WORDS_PER_OP=4).
// Checks csum as well when built with DUMP_CHECKSUM_EN.
module tb_dft_dump_collector;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        clr_err = 1'b0;
   logic        ack = 1'b0;
   logic        strobe = 1'b0;
   logic        commit = 1'b0;
   logic        rd_ready = 1'b0;
   logic [31:0] dout = '0;
   logic        busy, err, val_op, commit_ack, rd_valid;
   logic [1:0]  err_code;
   logic [31:0] rd_data;
   logic [6:0]  fill;
`ifdef DUMP_CHECKSUM_EN
   logic [31:0] csum;
`endif

   int ntests = 0;
   int nfail  = 0;
   logic [31:0] send_q[$];
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   dft_dump_collector #(
      .WORDS_PER_OP (4),
      .FIFO_DEPTH   (64),
      .ACK_TIMEOUT  (1024)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .busy           (busy),
      .err            (err),
      .clr_err        (clr_err),
      .err_code       (err_code),
      .dft_val_op     (val_op),
      .dft_op_ack     (ack),
      .dft_out        (dout),
      .dft_out_strobe (strobe),
      .dft_op_commit  (commit),
      .dft_commit_ack (commit_ack),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .fill           (fill)
`ifdef DUMP_CHECKSUM_EN
      ,
      .csum           (csum)
`endif
   );

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic wait_req;
      for (int i = 0; i < 50 && !val_op; i++) tick;
      ntests++;
      if (val_op !== 1'b1) begin
         nfail++;
         $display("FAIL wait_req val_op got %b exp 1", val_op);
      end
   endtask

   task automatic drain;
      got_q.delete();
      for (int i = 0; i < 100 && rd_valid; i++) begin
         got_q.push_back(rd_data);
         rd_ready = 1'b1;
         tick;
      end
      rd_ready = 1'b0;
   endtask

   task automatic check_drain(input string name);
      drain;
      ntests++;
      if (got_q.size() != exp_q.size()) begin
         nfail++;
         $display("FAIL %s count got %0d exp %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         ntests++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            nfail++;
            $display("FAIL %s word%0d got %h exp %h", name, i,
                     (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
         end
      end
   endtask

   task automatic do_op(input int dly, input bit co_ack, input bit co_com);
      start = 1'b1;
      tick;
      start = 1'b0;
      wait_req;
      repeat (dly) tick;
      ack = 1'b1;
      if (co_ack) begin
         strobe = 1'b1;
         dout = send_q.pop_front();
      end
      tick;
      ack = 1'b0;
      strobe = 1'b0;
      while (send_q.size() > (co_com ? 1 : 0)) begin
         strobe = 1'b1;
         dout = send_q.pop_front();
         tick;
      end
      strobe = 1'b0;
      commit = 1'b1;
      if (co_com && send_q.size() > 0) begin
         strobe = 1'b1;
         dout = send_q.pop_front();
      end
      tick;
      commit = 1'b0;
      strobe = 1'b0;
   endtask

   task automatic test_reset;
      tick;
      tick;
      ntests++;
      if ({val_op, commit_ack, busy, err, rd_valid} !== 5'b0) begin
         nfail++;
         $display("FAIL reset_flags got %b exp 00000",
                  {val_op, commit_ack, busy, err, rd_valid});
      end
      ntests++;
      if (err_code !== 2'd0) begin
         nfail++; $display("FAIL reset_code got %0d exp 0", err_code);
      end
      ntests++;
      if (fill !== 7'd0) begin
         nfail++; $display("FAIL reset_fill got %0d exp 0", fill);
      end
      reset = 1'b1;
      tick;
   endtask

   task automatic test_idle_strobe;
      strobe = 1'b1;
      dout = 32'hDEAD_BEEF;
      tick;
      strobe = 1'b0;
      tick;
      ntests++;
      if (fill !== 7'd0 || rd_valid !== 1'b0) begin
         nfail++;
         $display("FAIL idle_strobe fill got %0d exp 0", fill);
      end
   endtask

   task automatic test_basic;
      send_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      do_op(3, 1'b0, 1'b0);
      ntests++;
      if (commit_ack !== 1'b1 || val_op !== 1'b0) begin
         nfail++;
         $display("FAIL basic_cack got %b/%b exp 1/0", commit_ack, val_op);
      end
      tick;
      ntests++;
      if (commit_ack !== 1'b0 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL basic_cack_1cyc got %b/%b exp 0/0", commit_ack, busy);
      end
      ntests++;
      if (err !== 1'b0 || fill !== 7'd4) begin
         nfail++;
         $display("FAIL basic_state err %b fill %0d exp 0/4", err, fill);
      end
`ifdef DUMP_CHECKSUM_EN
      ntests++;
      if (csum !== 32'h0000_0022) begin
         nfail++; $display("FAIL basic_csum got %h exp 00000022", csum);
      end
`endif
      exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      check_drain("basic");
   endtask

   task automatic test_coincident;
      send_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
      do_op(1, 1'b1, 1'b1);
      tick;
      ntests++;
      if (err !== 1'b0 || fill !== 7'd4) begin
         nfail++;
         $display("FAIL coinc_state err %b fill %0d exp 0/4", err, fill);
      end
      exp_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
      check_drain("coinc");
   endtask

   task automatic test_mismatch;
      send_q = '{32'hC1, 32'hC2, 32'hC3};
      do_op(0, 1'b0, 1'b0);
      tick;
      ntests++;
      if (err !== 1'b1 || err_code !== 2'd3) begin
         nfail++;
         $display("FAIL mismatch_err got %b/%0d exp 1/3", err, err_code);
      end
      ntests++;
      if (fill !== 7'd3) begin
         nfail++; $display("FAIL mismatch_fill got %0d exp 3", fill);
      end
      exp_q = '{32'hC1, 32'hC2, 32'hC3};
      check_drain("mismatch");
      clr_err = 1'b1;
      tick;
      clr_err = 1'b0;
      ntests++;
      if (err !== 1'b0 || err_code !== 2'd0) begin
         nfail++;
         $display("FAIL clr_err got %b/%0d exp 0/0", err, err_code);
      end
   endtask

   task automatic test_simul_rw;
      start = 1'b1;
      tick;
      start = 1'b0;
      wait_req;
      ack = 1'b1;
      strobe = 1'b1;
      dout = 32'hB1;
      tick;
      ack = 1'b0;
      ntests++;
      if (fill !== 7'd1 || rd_data !== 32'hB1) begin
         nfail++;
         $display("FAIL rw_first fill %0d data %h exp 1/b1", fill, rd_data);
      end
      dout = 32'hB2;
      rd_ready = 1'b1;
      tick;
      ntests++;
      if (fill !== 7'd1 || rd_data !== 32'hB2) begin
         nfail++;
         $display("FAIL rw_simul1 fill %0d data %h exp 1/b2", fill, rd_data);
      end
      dout = 32'hB3;
      tick;
      ntests++;
      if (fill !== 7'd1 || rd_data !== 32'hB3) begin
         nfail++;
         $display("FAIL rw_simul2 fill %0d data %h exp 1/b3", fill, rd_data);
      end
      rd_ready = 1'b0;
      dout = 32'hB4;
      commit = 1'b1;
      tick;
      commit = 1'b0;
      strobe = 1'b0;
      ntests++;
      if (commit_ack !== 1'b1 || fill !== 7'd2) begin
         nfail++;
         $display("FAIL rw_commit cack %b fill %0d exp 1/2", commit_ack, fill);
      end
      tick;
      ntests++;
      if (err !== 1'b0) begin
         nfail++; $display("FAIL rw_err got %b exp 0", err);
      end
      exp_q = '{32'hB3, 32'hB4};
      check_drain("rw");
   endtask

   task automatic test_space;
      send_q.delete();
      for (int i = 0; i < 62; i++) send_q.push_back(32'h100 + i);
      do_op(0, 1'b0, 1'b0);
      tick;
      ntests++;
      if (fill !== 7'd62 || err_code !== 2'd3) begin
         nfail++;
         $display("FAIL space_preload fill %0d code %0d exp 62/3", fill, err_code);
      end
      clr_err = 1'b1;
      tick;
      clr_err = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (3) tick;
      ntests++;
      if (val_op !== 1'b0 || busy !== 1'b1) begin
         nfail++;
         $display("FAIL space_hold val_op %b busy %b exp 0/1", val_op, busy);
      end
      rd_ready = 1'b1;
      tick;
      tick;
      rd_ready = 1'b0;
      ntests++;
      if (fill !== 7'd60 || val_op !== 1'b0) begin
         nfail++;
         $display("FAIL space_drain fill %0d val_op %b exp 60/0", fill, val_op);
      end
      tick;
      ntests++;
      if (val_op !== 1'b1) begin
         nfail++; $display("FAIL space_req val_op got %b exp 1", val_op);
      end
      ack = 1'b1;
      tick;
      ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         strobe = 1'b1;
         dout = 32'h200 + i;
         tick;
      end
      strobe = 1'b0;
      commit = 1'b1;
      tick;
      commit = 1'b0;
      tick;
      ntests++;
      if (err_code !== 2'd2 || fill !== 7'd64) begin
         nfail++;
         $display("FAIL overflow code %0d fill %0d exp 2/64", err_code, fill);
      end
      clr_err = 1'b1;
      tick;
      clr_err = 1'b0;
      exp_q.delete();
      for (int i = 2; i < 62; i++) exp_q.push_back(32'h100 + i);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + i);
      check_drain("wrap");
   endtask

   task automatic test_timeout;
      int n;
      start = 1'b1;
      tick;
      start = 1'b0;
      wait_req;
      strobe = 1'b1;
      dout = 32'hEE;
      n = 0;
      while (val_op && n < 1100) begin
         n++;
         start = (n == 10);
         tick;
      end
      start = 1'b0;
      strobe = 1'b0;
      ntests++;
      if (n != 1024) begin
         nfail++; $display("FAIL tmo_cycles got %0d exp 1024", n);
      end
      ntests++;
      if (err !== 1'b1 || err_code !== 2'd1) begin
         nfail++;
         $display("FAIL tmo_err got %b/%0d exp 1/1", err, err_code);
      end
      ntests++;
      if (busy !== 1'b0 || val_op !== 1'b0 || fill !== 7'd0) begin
         nfail++;
         $display("FAIL tmo_idle busy %b val %b fill %0d exp 0/0/0",
                  busy, val_op, fill);
      end
      tick;
      tick;
      ntests++;
      if (busy !== 1'b0) begin
         nfail++; $display("FAIL tmo_start_ignored busy got %b exp 0", busy);
      end
      clr_err = 1'b1;
      tick;
      clr_err = 1'b0;
   endtask

   task automatic test_reset_mid;
      start = 1'b1;
      tick;
      start = 1'b0;
      wait_req;
      ack = 1'b1;
      tick;
      ack = 1'b0;
      strobe = 1'b1;
      dout = 32'hD1;
      tick;
      dout = 32'hD2;
      tick;
      strobe = 1'b0;
      ntests++;
      if (fill !== 7'd2 || busy !== 1'b1) begin
         nfail++;
         $display("FAIL mid_pre fill %0d busy %b exp 2/1", fill, busy);
      end
      reset = 1'b0;
      #1;
      ntests++;
      if ({val_op, commit_ack, busy, err, rd_valid, err_code} !== 7'b0 ||
          fill !== 7'd0) begin
         nfail++;
         $display("FAIL mid_reset outs %b fill %0d exp 0/0",
                  {val_op, commit_ack, busy, err, rd_valid, err_code}, fill);
      end
      tick;
      reset = 1'b1;
      tick;
      send_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      do_op(2, 1'b0, 1'b0);
      ntests++;
      if (commit_ack !== 1'b1) begin
         nfail++; $display("FAIL mid_cack got %b exp 1", commit_ack);
      end
      tick;
      ntests++;
      if (err !== 1'b0 || fill !== 7'd4) begin
         nfail++;
         $display("FAIL mid_clean err %b fill %0d exp 0/4", err, fill);
      end
`ifdef DUMP_CHECKSUM_EN
      ntests++;
      if (csum !== 32'h0000_0022) begin
         nfail++; $display("FAIL mid_csum got %h exp 00000022", csum);
      end
`endif
      exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      check_drain("mid_clean");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_idle_strobe;
      test_basic;
      test_coincident;
      test_mismatch;
      test_simul_rw;
      test_space;
      test_timeout;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/dft_dump_collector.md
Name: dft_dump_collector

Overview:
- Host-side stage directly downstream of the DFT top: issues scan-dump operations on the dft_val_op / dft_op_ack / dft_op_commit / dft_commit_ack handshake.
- Captures every dft_out word qualified by dft_out_strobe into an internal FIFO, then presents the words to the host on a valid/ready stream.
- Gates each new dump on guaranteed FIFO space, because the strobe stream cannot be stalled.

Parameters:
- WORDS_PER_OP, 32, dft_out words expected per operation (chain_len/32 * dump_nbr of the DFT block).
- FIFO_DEPTH, 64, capture FIFO entries; power of two; must be >= WORDS_PER_OP.
- ACK_TIMEOUT, 1024, cycles allowed from issue to dft_op_ack before error.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  host pulse: request one dump operation.
- busy  out  1  operation in flight (state != IDLE).
- err  out  1  sticky: timeout, overflow or word-count mismatch; cleared by clr_err.
- clr_err  in  1  clears err and err_code.
- err_code  out  2  0 none, 1 ack timeout, 2 overflow, 3 count mismatch.
- dft_val_op  out  1  operation request to DFT block.
- dft_op_ack  in  1  DFT accepted request.
- dft_out  in  32  scan data word.
- dft_out_strobe  in  1  dft_out valid this cycle.
- dft_op_commit  in  1  DFT operation finished.
- dft_commit_ack  out  1  acknowledge of commit.
- rd_data  out  32  FIFO head word.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  host consumes head when rd_valid.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE.
  - All outputs 0: dft_val_op, dft_commit_ack, busy, err, err_code, rd_valid, fill.
  - FIFO pointers 0, counters 0.
  - rd_data is don't-care while rd_valid=0.
- FSM states: IDLE, WAIT_SPACE, REQ, CAPTURE, COMMIT_ACK.
- IDLE:
  - start=1 -> WAIT_SPACE.
  - start while busy is ignored (not queued).
- WAIT_SPACE: free space (FIFO_DEPTH - fill) >= WORDS_PER_OP -> REQ; stays here otherwise.
- REQ:
  - dft_val_op=1, held until dft_op_ack sampled high.
  - Then go to CAPTURE with dft_val_op deasserted in that same transition.
  - Timeout counter increments each REQ cycle; reaching ACK_TIMEOUT sets err, err_code=1, returns to IDLE.
- CAPTURE:
  - Each strobe cycle writes dft_out to the FIFO; word counter increments.
  - A strobe in the same cycle as dft_op_ack is captured.
  - dft_op_commit=1 -> COMMIT_ACK.
  - A strobe coincident with commit is still captured.
- COMMIT_ACK:
  - dft_commit_ack=1 for exactly one cycle, then IDLE.
  - Word counter != WORDS_PER_OP at commit sets err, err_code=3; captured words are kept.
- FIFO:
  - Simultaneous write and read in the same cycle is allowed; fill is unchanged.
  - Read when empty: no effect.
  - Write when full: word dropped, err set, err_code=2, FSM continues.
  - Pointers wrap modulo FIFO_DEPTH.
  - rd_data is first-word-fall-through.
- Error precedence: the first error code latched sticks until clr_err; clr_err and a new error in the same cycle leave the new error set.
- Strobes outside CAPTURE are ignored.
- Reset mid-operation clears everything. The DFT side recovers via its own reset; no commit_ack is issued.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Enabled:
  - A 32-bit XOR-rotate checksum (csum = rotl(csum,1) ^ word) accumulates over captured words.
  - Cleared on entry to REQ.
  - Output port csum[31:0] valid from COMMIT_ACK until the next REQ.
- Disabled: no csum port and no checksum logic.

Decomposition:
- Package dft_collect_pkg holds:
  - state encoding constants (3-bit);
  - err_code constants;
  - the checksum step function.
- One sub-module, dft_capture_fifo: synchronous single-clock FWFT FIFO with fill count and overflow flag.
- FSM and counters stay in the top.

Test Plan:
- Basic dump, WORDS_PER_OP=4: start; ack after 3 cycles; 4 strobes (0x11,0x22,0x33,0x44); commit.
  - Expect dft_commit_ack one cycle.
  - rd stream 0x11..0x44 in order; err=0.
- Space gating: preload fill=62 with rd_ready=0; start -> stays WAIT_SPACE with dft_val_op=0. Drain 2 words -> REQ next cycle.
- Ack timeout: start, never ack -> after 1024 REQ cycles err=1, err_code=1, dft_val_op=0, busy=0.
- Count mismatch: 3 strobes then commit -> err_code=3, 3 words readable. clr_err -> err=0.
- Edge cases:
  - Strobe coincident with ack and with commit -> both captured.
  - Simultaneous read/write at fill=1 -> fill stays 1.
- Reset mid-CAPTURE after 2 strobes -> all outputs 0, fill=0. A following start runs a clean dump (DUMP_CHECKSUM_EN: csum of 0x11,0x22,0x33,0x44 matches model).
